// File: rtl/clk_set_pkg.sv
// clk_set_pkg: shared definitions for the real-clock time-set controller.
//   - FSM state encodings (RUN / SET_HH / SET_MM / COMMIT), matching state_o
//   - hh:mm field widths and wrap limits
//   - seven-segment blank masks for the field being edited
//   - wrap-around increment helpers for the edit registers
package clk_set_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SET_HH = 2'd1,
      SET_MM = 2'd2,
      COMMIT = 2'd3
   } state_t;

   localparam int HH_W = 5;
   localparam int MM_W = 6;

   localparam logic [HH_W-1:0] MAX_HH = 5'd23;
   localparam logic [MM_W-1:0] MAX_MM = 6'd59;

   localparam logic [3:0] BLINK_HH_MASK = 4'b1100;
   localparam logic [3:0] BLINK_MM_MASK = 4'b0011;

   // Hours step 0..23 and wrap back to 0.
   function automatic logic [HH_W-1:0] next_hh(input logic [HH_W-1:0] v);
      return (v == MAX_HH) ? '0 : v + HH_W'(1);
   endfunction

   // Minutes step 0..59 and wrap back to 0.
   function automatic logic [MM_W-1:0] next_mm(input logic [MM_W-1:0] v);
      return (v == MAX_MM) ? '0 : v + MM_W'(1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: turns one raw, asynchronous, active-high push button into a
// clean debounced level and a single-cycle press pulse.
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   btn    in  raw button level (asynchronous to clk)
//   level  out debounced button level
//   press  out one-cycle pulse on the debounced 0->1 edge
// A raw edge reaches the press pulse 2 + DEBOUNCE_CYC cycles later: two
// synchronizer flops, then DEBOUNCE_CYC equal samples before acceptance.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] stable_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0    <= 1'b0;
         sync_p1    <= 1'b0;
         stable_cnt <= '0;
         level      <= 1'b0;
         press      <= 1'b0;
      end else begin
         // stage p0/p1: metastability synchronizer
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
         // stability stage: count consecutive samples that differ from level
         press <= 1'b0;
         if (sync_p1 == level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_LAST) begin
            stable_cnt <= '0;
            level      <= sync_p1;
            press      <= sync_p1;
         end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/clk_set_ctrl.sv
// clk_set_ctrl: time-set controller for the Basys real-clock design.
// Two raw buttons drive an hh:mm edit sequence RUN -> SET_HH -> SET_MM ->
// COMMIT -> RUN; the edited time is handed to the counters with a one-cycle
// load strobe. The field being edited blinks at 2 Hz, and an edit with no
// press for TIMEOUT_S seconds is abandoned without a load.
//   clk         in  system clock
//   reset       in  asynchronous active-low reset (discards any edit)
//   mode        in  raw mode button
//   inc         in  raw increment button
//   cur_hh      in  current hours 0..23
//   cur_mm      in  current minutes 0..59
//   load        out one-cycle commit strobe
//   load_hh     out committed hours (held after load)
//   load_mm     out committed minutes (held after load)
//   set_active  out high in SET_HH/SET_MM
//   blink_mask  out per-digit blank request, [3:2] hours, [1:0] minutes
//   state_o     out FSM state for debug LEDs
// Build option: define CLK_SET_AUTOREPEAT_EN to enable inc auto-repeat every
// REPEAT_CYC cycles while inc is held in a SET state.
module clk_set_ctrl
   import clk_set_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int TIMEOUT_S    = 10
`ifdef CLK_SET_AUTOREPEAT_EN
   ,
   parameter int REPEAT_CYC   = 25_000_000
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mode,
   input  logic            inc,
   input  logic [HH_W-1:0] cur_hh,
   input  logic [MM_W-1:0] cur_mm,
   output logic            load,
   output logic [HH_W-1:0] load_hh,
   output logic [MM_W-1:0] load_mm,
   output logic            set_active,
   output logic [3:0]      blink_mask,
   output logic [1:0]      state_o
);

   localparam int BLINK_CYC = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
   localparam int BLINK_W   = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

   state_t state_q;
   state_t state_nxt;

   logic mode_level;
   logic mode_press;
   logic inc_level;
   logic inc_press;
   logic any_press;
   logic inc_evt;
   logic in_set;
   logic to_hit;
   logic lvl_unused;

   logic [HH_W-1:0]    edit_hh;
   logic [MM_W-1:0]    edit_mm;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_db (
      .clk   (clk),
      .reset (reset),
      .btn   (mode),
      .level (mode_level),
      .press (mode_press)
   );

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc_db (
      .clk   (clk),
      .reset (reset),
      .btn   (inc),
      .level (inc_level),
      .press (inc_press)
   );

   assign any_press = mode_press | inc_press;
   assign in_set    = (state_q == SET_HH) || (state_q == SET_MM);

   // Inactivity timeout; a press in the same cycle always cancels it.
   generate
      if (TIMEOUT_S > 0) begin : g_timeout
         localparam int TO_LIMIT = TIMEOUT_S * CLK_HZ;
         localparam int TO_W     = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;
         localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);
         logic [TO_W-1:0] to_cnt;

         assign to_hit = in_set && !any_press && (to_cnt == TO_LAST);

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               to_cnt <= '0;
            end else if (!in_set || any_press || to_hit) begin
               to_cnt <= '0;
            end else begin
               to_cnt <= to_cnt + TO_W'(1);
            end
         end
      end else begin : g_no_timeout
         assign to_hit = 1'b0;
      end
   endgenerate

`ifdef CLK_SET_AUTOREPEAT_EN
   localparam int REP_CYC = (REPEAT_CYC > 0) ? REPEAT_CYC : 1;
   localparam int REP_W   = (REP_CYC > 1) ? $clog2(REP_CYC) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CYC - 1);

   logic [REP_W-1:0] rep_cnt;
   logic             rep_hit;

   // The initial press restarts the interval, so repeats land REPEAT_CYC,
   // 2*REPEAT_CYC, ... cycles after the press pulse.
   assign rep_hit = in_set && inc_level && (rep_cnt == REP_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rep_cnt <= '0;
      end else if (!in_set || !inc_level || inc_press ||
                   (state_nxt != state_q) || rep_hit) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt + REP_W'(1);
      end
   end

   assign inc_evt    = inc_press | rep_hit;
   assign lvl_unused = mode_level;
`else
   assign inc_evt    = inc_press;
   assign lvl_unused = mode_level ^ inc_level;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic; mode has priority over inc and over the timeout.
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         RUN:     if (mode_press) state_nxt = SET_HH;
         SET_HH:  if (mode_press) state_nxt = SET_MM;
                  else if (to_hit) state_nxt = RUN;
         SET_MM:  if (mode_press) state_nxt = COMMIT;
                  else if (to_hit) state_nxt = RUN;
         COMMIT:  state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Outputs
   always_comb begin
      load       = 1'b0;
      set_active = 1'b0;
      blink_mask = '0;
      state_o    = state_q;
      unique case (state_q)
         SET_HH: begin
            set_active = 1'b1;
            if (blink_phase) blink_mask = BLINK_HH_MASK;
         end
         SET_MM: begin
            set_active = 1'b1;
            if (blink_phase) blink_mask = BLINK_MM_MASK;
         end
         COMMIT:  load = 1'b1;
         default: ;
      endcase
   end

   // Edit registers and committed copies; inc is dropped when mode fires.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         edit_hh <= '0;
         edit_mm <= '0;
         load_hh <= '0;
         load_mm <= '0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (mode_press) begin
                  edit_hh <= cur_hh;
                  edit_mm <= cur_mm;
               end
            end
            SET_HH: begin
               if (!mode_press && inc_evt) edit_hh <= next_hh(edit_hh);
            end
            SET_MM: begin
               if (mode_press) begin
                  load_hh <= edit_hh;
                  load_mm <= edit_mm;
               end else if (inc_evt) begin
                  edit_mm <= next_mm(edit_mm);
               end
            end
            default: ;
         endcase
      end
   end

   // Blink timebase; every press (including the one entering a SET state)
   // restarts it visible so the user sees the new value immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (!in_set || any_press) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + BLINK_W'(1);
      end
   end

endmodule
